// File: rtl/instr_word_assembler_if.sv
// Fetch-side and instruction-side handshake bundle for the instruction word assembler.
// The slave modport is the assembler's view; the master modport is the surrounding pipeline's.
interface instr_word_assembler_if;
  logic [31:0] fetchWord;
  logic        fetchValid;
  logic        fetchReady;
  logic [63:0] outWord;
  logic [63:0] outWordL;
  logic [1:0]  outLen;
  logic        outValid;
  logic        outReady;

  modport slave (
    input  fetchWord, fetchValid, outReady,
    output fetchReady, outWord, outWordL, outLen, outValid
  );

  modport master (
    output fetchWord, fetchValid, outReady,
    input  fetchReady, outWord, outWordL, outLen, outValid
  );
endinterface

// File: rtl/instr_word_assembler.sv
// Packs 32-bit fetch words into 16/32/48-bit instructions, absorbing up to two FE jumbo prefixes.
// One-cycle fetch-to-output latency; fetch stalls once more than 6 halfwords are buffered.
module instr_word_assembler (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  instr_word_assembler_if.slave  bus
);
  logic [127:0] buf_q, buf_d;
  logic [3:0]   hc_q, hc_d;
  logic [1:0]   jc_q, jc_d;
  logic [63:0]  wl_q, wl_d;

  logic [15:0]  head;
  logic [1:0]   len;
  logic         is_prefix;
  logic         absorb;
  logic         out_vld;
  logic         emit;
  logic         push;
  logic [3:0]   pop_cnt;
  logic [3:0]   rem;

  always_comb begin
    head = buf_q[15:0];
    // FE would decode as 48-bit by its opcode bits, but once not absorbed it is a 32-bit op.
    if (head[15:8] == 8'hFE)           len = 2'd2;
    else if (head[15:13] != 3'b111)    len = 2'd1;
    else if (head[11:10] == 2'b11)     len = 2'd3;
    else                               len = 2'd2;

    is_prefix = (hc_q != 4'd0) && (head[15:8] == 8'hFE) && (jc_q != 2'd2);
    absorb    = is_prefix && (hc_q >= 4'd2);
    out_vld   = !is_prefix && (hc_q >= {2'b00, len});
    emit      = out_vld && bus.outReady;
    push      = bus.fetchValid && bus.fetchReady;

    if (absorb)    pop_cnt = 4'd2;
    else if (emit) pop_cnt = {2'b00, len};
    else           pop_cnt = 4'd0;
    rem = hc_q - pop_cnt;
  end

  always_comb begin
    // Slots above HC are always zero, so OR-ing the new word in behind the survivors is safe.
    buf_d = buf_q >> {pop_cnt, 4'b0000};
    if (push) buf_d = buf_d | ({96'd0, bus.fetchWord} << {rem, 4'b0000});
    hc_d = push ? rem + 4'd2 : rem;
    jc_d = jc_q;
    wl_d = wl_q;
    if (absorb) begin
      jc_d = jc_q + 2'd1;
      if (jc_q == 2'd0) wl_d[31:0]  = buf_q[31:0];
      else              wl_d[63:32] = buf_q[31:0];
    end else if (emit) begin
      jc_d = 2'd0;
      wl_d = 64'd0;
    end
    if (flush) begin
      buf_d = 128'd0;
      hc_d  = 4'd0;
      jc_d  = 2'd0;
      wl_d  = 64'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q <= 128'd0;
      hc_q  <= 4'd0;
      jc_q  <= 2'd0;
      wl_q  <= 64'd0;
    end else begin
      buf_q <= buf_d;
      hc_q  <= hc_d;
      jc_q  <= jc_d;
      wl_q  <= wl_d;
    end
  end

  assign bus.fetchReady = (hc_q <= 4'd6) && !flush;
  assign bus.outValid   = out_vld;
  assign bus.outLen     = out_vld ? len : 2'd0;
  assign bus.outWordL   = out_vld ? wl_q : 64'd0;

  always_comb begin
    bus.outWord = 64'd0;
    if (out_vld) begin
      case (len)
        2'd1:    bus.outWord = {48'd0, buf_q[15:0]};
        2'd2:    bus.outWord = {32'd0, buf_q[31:0]};
        default: bus.outWord = {16'd0, buf_q[47:0]};
      endcase
    end
  end
endmodule

// File: tb/tb_instr_word_assembler.sv
// Directed bench: a per-cycle vector table plus a hand sequence for a slowly completed 48-bit op.
module tb_instr_word_assembler;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  instr_word_assembler_if bus ();

  instr_word_assembler dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        fv;
    logic [31:0] fw;
    logic        ordy;
    logic        vld;
    logic [1:0]  len;
    logic [63:0] ow;
    logic [63:0] owl;
    logic        frdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic fl, input logic fv, input logic [31:0] fw,
                     input logic ordy, input logic vld, input logic [1:0] len,
                     input logic [63:0] ow, input logic [63:0] owl, input logic frdy);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fv = fv; v.fw = fw; v.ordy = ordy;
    v.vld = vld; v.len = len; v.ow = ow; v.owl = owl; v.frdy = frdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return to idle inputs shortly after the edge.
  task automatic step(input logic rst, input logic fl, input logic fv, input logic [31:0] fw,
                      input logic ordy);
    reset = rst; flush = fl; bus.fetchValid = fv; bus.fetchWord = fw; bus.outReady = ordy;
    @(posedge clock);
    #1;
    reset = 1'b0; flush = 1'b0; bus.fetchValid = 1'b0; bus.fetchWord = 32'd0; bus.outReady = 1'b0;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [1:0] len,
                         input logic [63:0] ow, input logic [63:0] owl, input logic frdy);
    chk({tag, ".outValid"},   {63'd0, bus.outValid},   {63'd0, vld});
    chk({tag, ".outLen"},     {62'd0, bus.outLen},     {62'd0, len});
    chk({tag, ".outWord"},    bus.outWord,             ow);
    chk({tag, ".outWordL"},   bus.outWordL,            owl);
    chk({tag, ".fetchReady"}, {63'd0, bus.fetchReady}, {63'd0, frdy});
  endtask

  initial begin
    bus.fetchValid = 1'b0;
    bus.fetchWord  = 32'd0;
    bus.outReady   = 1'b0;

    //   rst fl fv fetchWord       rdy  vld len outWord                 outWordL                frdy
    add(1, 0, 0, 32'h0,          0,   0, 0, 64'h0,                  64'h0,                  1); // reset
    add(0, 0, 1, 32'hF000_1234,  1,   1, 1, 64'h1234,               64'h0,                  1);
    add(0, 0, 1, 32'h3003_4002,  1,   1, 2, 64'h0000_0000_4002_F000, 64'h0,                 1);
    add(0, 0, 0, 32'h0,          1,   1, 1, 64'h3003,               64'h0,                  1);
    add(0, 0, 0, 32'h0,          1,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'h5678_FE12,  1,   0, 0, 64'h0,                  64'h0,                  1); // prefix
    add(0, 0, 1, 32'h9ABC_F012,  0,   1, 2, 64'h9ABC_F012,          64'h5678_FE12,          1);
    add(0, 0, 0, 32'h0,          1,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'h1111_FE01,  0,   0, 0, 64'h0,                  64'h0,                  1); // 3 prefixes
    add(0, 0, 1, 32'h2222_FE02,  0,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'h3333_FE03,  0,   1, 2, 64'h3333_FE03,          64'h2222_FE02_1111_FE01, 1);
    add(0, 0, 1, 32'h4444_F055,  0,   1, 2, 64'h3333_FE03,          64'h2222_FE02_1111_FE01, 1);
    add(0, 0, 0, 32'h0,          1,   1, 2, 64'h4444_F055,          64'h0,                  1);
    add(0, 0, 0, 32'h0,          1,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'hAAAA_FC00,  0,   0, 0, 64'h0,                  64'h0,                  1); // partial 48
    add(0, 0, 1, 32'hCCCC_BBBB,  0,   1, 3, 64'h0000_BBBB_AAAA_FC00, 64'h0,                 1);
    add(0, 0, 0, 32'h0,          1,   1, 1, 64'h0000_0000_0000_CCCC, 64'h0,                 1);
    add(0, 0, 0, 32'h0,          1,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'h0002_0001,  0,   1, 1, 64'h0001,               64'h0,                  1); // fill
    add(0, 0, 1, 32'h0004_0003,  0,   1, 1, 64'h0001,               64'h0,                  1);
    add(0, 0, 1, 32'h0006_0005,  0,   1, 1, 64'h0001,               64'h0,                  1);
    add(0, 0, 1, 32'h0008_0007,  0,   1, 1, 64'h0001,               64'h0,                  0);
    add(0, 0, 1, 32'h000A_0009,  0,   1, 1, 64'h0001,               64'h0,                  0);
    add(0, 1, 1, 32'h000A_0009,  1,   0, 0, 64'h0,                  64'h0,                  1); // flush
    add(0, 0, 0, 32'h0,          0,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'h7777_FE07,  0,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'h8888_FE08,  0,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 1, 0, 32'h0,          0,   0, 0, 64'h0,                  64'h0,                  1); // flush jumbo
    add(0, 0, 1, 32'h9999_F011,  0,   1, 2, 64'h9999_F011,          64'h0,                  1);
    add(0, 0, 0, 32'h0,          1,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'hFE10_4040,  0,   1, 1, 64'h4040,               64'h0,                  1);
    add(0, 0, 1, 32'hAB01_1010,  1,   0, 0, 64'h0,                  64'h0,                  1);
    add(0, 0, 1, 32'hCDCD_EFEF,  0,   1, 1, 64'hAB01,               64'h0000_0000_1010_FE10, 1);
    add(1, 1, 1, 32'h1234_5678,  1,   0, 0, 64'h0,                  64'h0,                  1); // reset mid
    add(0, 0, 0, 32'h0,          0,   0, 0, 64'h0,                  64'h0,                  1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].fv, vecs[i].fw, vecs[i].ordy);
      chk_out($sformatf("v%0d", i), vecs[i].vld, vecs[i].len, vecs[i].ow, vecs[i].owl, vecs[i].frdy);
    end

    // 48-bit op whose tail arrives after several idle cycles.
    step(0, 0, 1, 32'h0000_EC01, 1);
    chk_out("ec.part", 0, 0, 64'h0, 64'h0, 1);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 32'h0, 1);
      chk_out($sformatf("ec.wait%0d", k), 0, 0, 64'h0, 64'h0, 1);
    end
    step(0, 0, 1, 32'h0077_0066, 1);
    chk_out("ec.full", 1, 3, 64'h0000_0066_0000_EC01, 64'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk_out("ec.tail", 1, 1, 64'h0077, 64'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk_out("ec.empty", 0, 0, 64'h0, 64'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
